// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-fetch / write-back stage placed in front of a combinational ALU.
// Holds a register file and processes one instruction at a time:
//
//   accept (IDLE) -> READ (operands registered) -> EXEC (ALU settles)
//                 -> WB (result written back)   -> IDLE with done pulse
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   instruction handshake
//   rs, rt, rd          source A, source B, destination register addresses
//   imm, use_imm        16-bit immediate, sign-extended into B when use_imm=1
//   ld_en/addr/data     direct register load, honoured in IDLE only
//   alu_A, alu_B        registered operands driven to the ALU
//   alu_result          combinational result returned by the ALU
//   done                one-cycle pulse in the cycle after the write-back edge
//   wb_data             value written on the most recent write-back
//   dbg_addr, dbg_data  combinational register read
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE, only while no load
// is requested and only outside reset; in_valid may drop or change freely
// after the transfer edge because every instruction field is latched then.
//
// Register 0 always reads as zero: it is cleared by reset and never written.
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     rs,
    input  logic [AW-1:0]     rt,
    input  logic [AW-1:0]     rd,
    input  logic [15:0]       imm,
    input  logic              use_imm,

    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,

    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    input  logic [DATA_W-1:0] alu_result,

    output logic              done,
    output logic [DATA_W-1:0] wb_data,

    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t              state_q, state_d;

    // Latched instruction fields
    logic [AW-1:0]       rs_q, rs_d;
    logic [AW-1:0]       rt_q, rt_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [15:0]         imm_q, imm_d;
    logic                use_imm_q, use_imm_d;

    // Operand, result and status registers
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                done_q, done_d;

    // Register file
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];

    logic                accept_ok;
    logic [DATA_W-1:0]   imm_sext;

    // A pending load blocks acceptance in the same cycle: load wins.
    assign accept_ok = (state_q == IDLE) && !ld_en;
    assign in_ready  = accept_ok && !rst;

    assign imm_sext  = {{(DATA_W-16){imm_q[15]}}, imm_q};

    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        wb_data_d = wb_data_q;
        done_d    = 1'b0;
        regs_d    = regs_q;

        case (state_q)
            IDLE: begin
                if (ld_en) begin
                    // Loads to register 0 are dropped to keep it zero.
                    if (ld_addr != '0) begin
                        regs_d[ld_addr] = ld_data;
                    end
                end else if (in_valid) begin
                    rs_d      = rs;
                    rt_d      = rt;
                    rd_d      = rd;
                    imm_d     = imm;
                    use_imm_d = use_imm;
                    state_d   = READ;
                end
            end
            READ: begin
                // The only edge on which the operands change.
                alu_a_d = regs_q[rs_q];
                alu_b_d = use_imm_q ? imm_sext : regs_q[rt_q];
                state_d = EXEC;
            end
            EXEC: begin
                // Operands held one full cycle so the ALU output settles.
                state_d = WB;
            end
            WB: begin
                wb_data_d = alu_result;
                if (rd_q != '0) begin
                    regs_d[rd_q] = alu_result;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            wb_data_q <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            wb_data_q <= wb_data_d;
            done_q    <= done_d;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign alu_A    = alu_a_q;
    assign alu_B    = alu_b_q;
    assign done     = done_q;
    assign wb_data  = wb_data_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Bench for alu_operand_stage. The ALU is modelled here as a small
// combinational block selected by alu_op (XOR, AND, ADD, OR). A register
// array mirrors the expected register file contents; expected write-back
// values are queued in exp_q and popped whenever done is seen.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam logic [1:0] OP_XOR = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic        use_imm = 1'b0;
    logic        ld_en = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        done;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [1:0]  alu_op = OP_XOR;

    alu_operand_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .use_imm    (use_imm),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_A      (alu_a),
        .alu_B      (alu_b),
        .alu_result (alu_result),
        .done       (done),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Combinational ALU attached to the stage
    always_comb begin
        case (alu_op)
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_ADD:  alu_result = alu_a + alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_r [32];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_ADD:  return a + b;
            default: return a | b;
        endcase
    endfunction

    // Every done pulse must match the oldest pending write-back.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending write-back");
            end else begin
                check("wb_data", wb_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Both tasks start and end just after a falling edge with the DUT idle.
    task automatic do_load(input logic [4:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        #1;
        check("load_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
        if (a != 5'd0) model_r[a] = d;
        dbg_addr = a;
        #1;
        check("load_dbg", dbg_data, model_r[a]);
    endtask

    task automatic issue(input logic [4:0] rs_i, input logic [4:0] rt_i, input logic [4:0] rd_i,
                         input logic [15:0] imm_i, input logic use_imm_i, input logic [1:0] op_i,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] er);
        in_valid = 1'b1;
        rs       = rs_i;
        rt       = rt_i;
        rd       = rd_i;
        imm      = imm_i;
        use_imm  = use_imm_i;
        alu_op   = op_i;
        exp_q.push_back(er);
        #1;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);                 // accept edge
        @(negedge clk);                 // cycle 1: READ
        // Scramble inputs and request loads that must be ignored while busy.
        in_valid = 1'($urandom_range(0, 1));
        rs       = 5'($urandom);
        rt       = 5'($urandom);
        rd       = 5'($urandom);
        imm      = 16'($urandom);
        use_imm  = 1'($urandom_range(0, 1));
        ld_en    = 1'b1;
        ld_addr  = 5'($urandom);
        ld_data  = $urandom;
        check("busy_ready", 32'(in_ready), 32'd0);
        check("no_early_done", 32'(done), 32'd0);
        @(negedge clk);                 // cycle 2: EXEC
        check("alu_A", alu_a, ea);
        check("alu_B", alu_b, eb);
        @(negedge clk);                 // cycle 3: WB
        check("alu_A_held", alu_a, ea);
        check("alu_B_held", alu_b, eb);
        in_valid = 1'b0;
        @(negedge clk);                 // cycle 4: IDLE, done
        ld_en = 1'b0;
        check("done_cycle4", 32'(done), 32'd1);
        if (rd_i != 5'd0) model_r[rd_i] = er;
        dbg_addr = rd_i;
        #1;
        check("wb_reg", dbg_data, (rd_i == 5'd0) ? 32'd0 : er);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic        use_imm;
        logic [1:0]  op;
        logic [31:0] exp_a, exp_b, exp_res;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [4:0]  r_rs, r_rt, r_rd, r_la;
        logic [15:0] r_imm;
        logic        r_ui;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b, r_ld;

        for (int i = 0; i < 32; i++) model_r[i] = 32'd0;

        tbl[0] = '{5'd1, 5'd2, 5'd3,  16'h0000, 1'b0, OP_XOR, 32'h3B9ACA07, 32'h0000008F, 32'h3B9ACA88};
        tbl[1] = '{5'd4, 5'd5, 5'd6,  16'h0000, 1'b0, OP_XOR, 32'h000F4335, 32'h00020D16, 32'h000D4E23};
        tbl[2] = '{5'd1, 5'd0, 5'd8,  16'h8000, 1'b1, OP_XOR, 32'h3B9ACA07, 32'hFFFF8000, 32'hC4654A07};
        tbl[3] = '{5'd1, 5'd0, 5'd9,  16'h7FFF, 1'b1, OP_ADD, 32'h3B9ACA07, 32'h00007FFF, 32'h3B9B4A06};
        tbl[4] = '{5'd1, 5'd2, 5'd0,  16'h0000, 1'b0, OP_AND, 32'h3B9ACA07, 32'h0000008F, 32'h00000007};
        tbl[5] = '{5'd4, 5'd5, 5'd7,  16'h0000, 1'b0, OP_XOR, 32'h000F4335, 32'h00020D16, 32'h000D4E23};
        tbl[6] = '{5'd7, 5'd2, 5'd10, 16'h0000, 1'b0, OP_XOR, 32'h000D4E23, 32'h0000008F, 32'h000D4EAC};
        tbl[7] = '{5'd3, 5'd6, 5'd13, 16'h0000, 1'b0, OP_OR,  32'h3B9ACA88, 32'h000D4E23, 32'h3B9FCEAB};

        // ---- reset state (asynchronous: checked without a clock edge) ----
        #1 rst = 1'b1;
        #1;
        check("rst_alu_A", alu_a, 32'd0);
        check("rst_alu_B", alu_b, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // ---- directed table (XOR pairs, immediates, R0, RAW hazard) ----
        do_load(5'd1, 32'h3B9ACA07);
        do_load(5'd2, 32'd143);
        do_load(5'd4, 32'd1000245);
        do_load(5'd5, 32'd134422);
        do_load(5'd0, 32'hDEADBEEF);    // discarded, dbg R0 stays 0
        // Entries run back to back: each accept lands in the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].use_imm, tbl[i].op,
                  tbl[i].exp_a, tbl[i].exp_b, tbl[i].exp_res);
        end
        dbg_addr = 5'd0;
        #1;
        check("r0_zero", dbg_data, 32'd0);

        // ---- load / issue collision ----
        @(negedge clk);
        ld_en    = 1'b1;
        ld_addr  = 5'd11;
        ld_data  = 32'hA5A5_0F0F;
        in_valid = 1'b1;
        rs       = 5'd11;
        rt       = 5'd0;
        rd       = 5'd12;
        use_imm  = 1'b0;
        #1;
        check("collide_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        ld_en = 1'b0;
        model_r[11] = 32'hA5A5_0F0F;
        dbg_addr = 5'd11;
        #1;
        check("collide_load", dbg_data, 32'hA5A5_0F0F);
        check("collide_not_taken", 32'(in_ready), 32'd1);
        check("collide_no_done", 32'(done), 32'd0);
        issue(5'd11, 5'd0, 5'd12, 16'h0, 1'b0, OP_XOR, 32'hA5A5_0F0F, 32'd0, 32'hA5A5_0F0F);

        // ---- randomized instructions against the reference model ----
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r_la = 5'($urandom);
                r_ld = $urandom;
                do_load(r_la, r_ld);
            end
            r_rs  = 5'($urandom);
            r_rt  = 5'($urandom);
            r_rd  = 5'($urandom_range(0, 15));
            r_imm = 16'($urandom);
            r_ui  = 1'($urandom_range(0, 1));
            r_op  = 2'($urandom_range(0, 3));
            r_a   = model_r[r_rs];
            r_b   = r_ui ? 32'($signed(r_imm)) : model_r[r_rt];
            issue(r_rs, r_rt, r_rd, r_imm, r_ui, r_op, r_a, r_b, ref_alu(r_op, r_a, r_b));
        end

        // ---- reset in the middle of EXEC abandons the instruction ----
        do_load(5'd1, 32'd5);
        in_valid = 1'b1;
        rs       = 5'd1;
        rt       = 5'd1;
        rd       = 5'd2;
        use_imm  = 1'b0;
        alu_op   = OP_ADD;
        @(posedge clk);
        @(negedge clk);                 // READ
        in_valid = 1'b0;
        @(negedge clk);                 // EXEC
        check("pre_rst_alu_A", alu_a, 32'd5);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) model_r[i] = 32'd0;
        check("midrst_alu_A", alu_a, 32'd0);
        check("midrst_alu_B", alu_b, 32'd0);
        check("midrst_wb_data", wb_data, 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        dbg_addr = 5'd1;
        #1;
        check("midrst_dbg_r1", dbg_data, 32'd0);
        @(negedge clk);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        #1;
        check("after_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_wb_after_rst", 32'(done), 32'd0);
        end
        dbg_addr = 5'd2;
        #1;
        check("abandoned_rd", dbg_data, 32'd0);

        // ---- stage works normally after reset ----
        do_load(5'd1, 32'h0000_1234);
        issue(5'd1, 5'd0, 5'd2, 16'h0001, 1'b1, OP_ADD, 32'h0000_1234, 32'd1, 32'h0000_1235);

        @(negedge clk);
        check("pending_wb", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
